cnn_mem_reader: RTL

Bus initiator for the CNN byte memory. It issues single-byte reads (chipselect+read, one-cycle read latency) over a contiguous address window. The returned bytes go out on a valid/ready byte stream to the CNN datapath, where they are consumed as parameter or image vectors. A start/done handshake with the HPS-side control register launches each transfer; an internal skid FIFO absorbs consumer backpressure without losing in-flight read data.

---
 rtl/cnn_mem_pkg.sv | 14 +
 rtl/cnn_byte_fifo.sv | 55 +++++
 rtl/cnn_mem_reader.sv | 132 +++++++++++++
 3 files changed

// File: rtl/cnn_mem_pkg.sv
// Shared types and widths for the CNN byte-memory bus initiators.
package cnn_mem_pkg;

  localparam int CNN_ADDR_W = 32;
  localparam int CNN_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/cnn_byte_fifo.sv
// Small skid FIFO for byte-plus-tag entries. The head entry is read straight
// from the storage registers, so it is valid one cycle after the push.
module cnn_byte_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 9,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic [CNT_W-1:0] count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W-1:0] wr_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic             do_pop;
  logic             do_push;

  // A pop frees a slot in the same cycle, so push into a full FIFO is allowed alongside it
  always_comb begin
    do_pop  = pop_i && (count_q != '0);
    do_push = push_i && ((count_q != CNT_W'(DEPTH)) || do_pop);
    count_d = count_q;
    if (do_push && !do_pop) count_d = count_q + 1'b1;
    if (do_pop && !do_push) count_d = count_q - 1'b1;
  end

  // Storage, pointers and occupancy; pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/cnn_mem_reader.sv
// Reads a contiguous byte window from CNN memory and streams it out on a
// valid/ready interface. Reads are only issued when the skid FIFO is sure to
// have room for the returning byte, so backpressure never drops data.
module cnn_mem_reader
  import cnn_mem_pkg::*;
#(
  parameter int ADDR_W     = CNN_ADDR_W,
  parameter int LEN_W      = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  length,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] m_address,
  output logic              m_chipselect,
  output logic              m_read,
  output logic              m_write,
  input  logic [7:0]        m_readdata,
  output logic [7:0]        out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  state_e            state_q;
  logic              busy_q;
  logic              done_q;
  logic [ADDR_W-1:0] base_q;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  issued_q;
  logic [LEN_W-1:0]  issued_d;
  logic              inflight_q;
  logic              last_q;

  logic [CNT_W-1:0]  fifo_count;
  logic [8:0]        fifo_head;
  logic [CNT_W:0]    occupancy;
  logic              issue;
  logic              pop;
  logic              drain_done;

  // Issue a read only if the FIFO plus the byte already in flight leaves a free slot
  always_comb begin
    issued_d   = issued_q + 1'b1;
    occupancy  = {1'b0, fifo_count} + (CNT_W + 1)'(inflight_q);
    issue      = (state_q == RUN) && (issued_q < len_q) &&
                 (occupancy < (CNT_W + 1)'(FIFO_DEPTH));
    pop        = (fifo_count != '0) && out_ready;
    drain_done = !inflight_q &&
                 ((fifo_count == '0) || ((fifo_count == CNT_W'(1)) && pop));
  end

  // Transfer control FSM with registered busy/done and read bookkeeping
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      base_q     <= '0;
      len_q      <= '0;
      issued_q   <= '0;
      inflight_q <= 1'b0;
      last_q     <= 1'b0;
    end else begin
      inflight_q <= issue;
      last_q     <= issue && (issued_d == len_q);
      if (issue) issued_q <= issued_d;
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            base_q   <= base_addr;
            len_q    <= length;
            issued_q <= '0;
            busy_q   <= 1'b1;
            if (length == '0) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= RUN;
            end
          end
        end
        RUN: begin
          if (issued_q == len_q) state_q <= DRAIN;
        end
        DRAIN: begin
          // Finish as soon as the last byte leaves this cycle, so done follows it directly
          if (drain_done) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  cnn_byte_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (9)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (reset),
    .push_i  (inflight_q),
    .data_i  ({last_q, m_readdata}),
    .pop_i   (pop),
    .head_o  (fifo_head),
    .count_o (fifo_count)
  );

  assign busy         = busy_q;
  assign done         = done_q;
  assign m_read       = issue;
  assign m_chipselect = issue;
  assign m_write      = 1'b0;
  assign m_address    = issue ? (base_q + ADDR_W'(issued_q)) : '0;
  assign out_valid    = (fifo_count != '0);
  assign out_data     = fifo_head[7:0];
  assign out_last     = out_valid && fifo_head[8];

endmodule
